// File: rtl/twos_to_signmag_pkg.sv
// Shared ALU decode types: FSM state encoding and default operand width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/twos_to_signmag_if.sv
// Valid/ready word channel into the sign-magnitude decoder and its result channel back out.
interface twos_to_signmag_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_ovf
  );

endinterface

// File: rtl/twos_to_signmag_neg_bit_cell.sv
// One-bit serial negation cell: copy bits up to and including the first 1, invert after it.
// Combinational, no latency, no flow control.
module neg_bit_cell (
  input  logic b,
  input  logic seen_in,
  output logic o,
  output logic seen_out
);

  assign o        = seen_in ? ~b : b;
  assign seen_out = seen_in | b;

endmodule

// File: rtl/twos_to_signmag.sv
// Two's-complement to sign-magnitude decoder; non-negative words take 1 cycle, negative WIDTH cycles.
// Accepts only in IDLE; result is held in DONE until out_ready, so input stalls behind a stalled output.
module twos_to_signmag
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  twos_to_signmag_if.slave    bus,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             valid_q;
  logic             sign_q;
  logic [WIDTH-1:0] mag_q;
  logic             ovf_q;

  logic             cell_o;
  logic             cell_seen;
  logic [WIDTH-1:0] mag_next;

  neg_bit_cell u_cell (
    .b        (sr[0]),
    .seen_in  (seen_one),
    .o        (cell_o),
    .seen_out (cell_seen)
  );

  // Serial result enters at the MSB so after WIDTH shifts bit 0 sits at mag[0].
  assign mag_next = {cell_o, mag_q[WIDTH-1:1]};

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = valid_q;
  assign bus.out_sign  = sign_q;
  assign bus.out_mag   = mag_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      valid_q  <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr       <= bus.in_data;
            sign_q   <= bus.in_data[WIDTH-1];
            seen_one <= 1'b0;
            cnt      <= '0;
            ovf_q    <= 1'b0;
            if (!bus.in_data[WIDTH-1]) begin
              mag_q   <= bus.in_data;
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              mag_q <= '0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          sr       <= sr >> 1;
          mag_q    <= mag_next;
          seen_one <= cell_seen;
          if (cnt == CNT_LAST) begin
            ovf_q   <= sign_q && (mag_next == MAG_MIN);
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Directed-vector bench for twos_to_signmag; each task checks its own scenario inline.
module tb_twos_to_signmag;

  localparam int W = 32;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  twos_to_signmag_if #(.WIDTH(W)) bus ();

  twos_to_signmag #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a word from a negedge and hold it until the edge that accepts it (edge k).
  task automatic accept_word(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout data=%h in_ready=%b required 1", d, bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_timeout out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd5;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d in_ready=%b out_valid=%b busy=%b required 0/0/0",
                 i, bus.in_ready, bus.out_valid, busy);
      end
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b required 1/0", bus.in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sign !== 1'b0 || bus.out_mag !== 32'd0 ||
        bus.out_ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_nothing_consumed valid=%b sign=%b mag=%h ovf=%b busy=%b required 0/0/0/0/0",
               bus.out_valid, bus.out_sign, bus.out_mag, bus.out_ovf, busy);
    end
  endtask

  task automatic test_nonneg();
    bus.out_ready = 1'b1;
    accept_word(32'h0000_0005);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sign !== 1'b0 || bus.out_mag !== 32'h0000_0005 ||
        bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL nonneg valid=%b sign=%b mag=%h ovf=%b required 1/0/00000005/0",
               bus.out_valid, bus.out_sign, bus.out_mag, bus.out_ovf);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nonneg_return in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_negative();
    int early;
    early = 0;
    accept_word(32'hF0F0_F0F0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL negative_shift_phase bad_cycles=%0d required 0", early);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sign !== 1'b1 || bus.out_mag !== 32'h0F0F_0F10 ||
        bus.out_ovf !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL negative valid=%b sign=%b mag=%h ovf=%b busy=%b required 1/1/0f0f0f10/0/1",
               bus.out_valid, bus.out_sign, bus.out_mag, bus.out_ovf, busy);
    end
    release_result();
  endtask

  task automatic test_boundaries();
    logic [W-1:0] vin  [3];
    logic [W-1:0] vmag [3];
    logic         vsgn [3];
    logic         vovf [3];
    vin[0] = 32'hFFFF_FFFF; vmag[0] = 32'h0000_0001; vsgn[0] = 1'b1; vovf[0] = 1'b0;
    vin[1] = 32'h8000_0000; vmag[1] = 32'h8000_0000; vsgn[1] = 1'b1; vovf[1] = 1'b1;
    vin[2] = 32'h0000_0000; vmag[2] = 32'h0000_0000; vsgn[2] = 1'b0; vovf[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      accept_word(vin[i]);
      @(negedge clk);
      wait_valid(W + 4);
      checks++;
      if (bus.out_sign !== vsgn[i] || bus.out_mag !== vmag[i] || bus.out_ovf !== vovf[i]) begin
        errors++;
        $display("FAIL boundary in=%h sign=%b mag=%h ovf=%b required %b/%h/%b",
                 vin[i], bus.out_sign, bus.out_mag, bus.out_ovf, vsgn[i], vmag[i], vovf[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    accept_word(32'h0000_0007);
    @(negedge clk);
    wait_valid(4);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_mag !== 32'h0000_0007 || bus.out_sign !== 1'b0 ||
          bus.in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold bad_cycles=%0d required 0", bad);
    end
    release_result();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.out_sign !== 1'b1) begin
      errors++;
      $display("FAIL second_word_accept busy=%b sign=%b required 1/1", busy, bus.out_sign);
    end
    wait_valid(W + 4);
    checks++;
    if (bus.out_mag !== 32'h0000_0003 || bus.out_sign !== 1'b1) begin
      errors++;
      $display("FAIL second_word mag=%h sign=%b required 00000003/1", bus.out_mag, bus.out_sign);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    accept_word(32'hFFFF_0000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b out_valid=%b required 0/0", busy, bus.out_valid);
    end
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_no_valid bad_cycles=%0d required 0", bad);
    end
    accept_word(32'hFFFF_FFFE);
    @(negedge clk);
    wait_valid(W + 4);
    checks++;
    if (bus.out_sign !== 1'b1 || bus.out_mag !== 32'h0000_0002 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_followup sign=%b mag=%h ovf=%b required 1/00000002/0",
               bus.out_sign, bus.out_mag, bus.out_ovf);
    end
    release_result();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_nonneg();
    test_negative();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
